seq_mult_ctrl: RTL and testbench

Control-and-accumulator stage of the shift-add sequential multiplier. It sits directly upstream of the multiplier/low-product shift register: it loads that register, drives its shift-right and serial-in inputs, and consumes its serial-out bit (current multiplier LSB). Internally it holds the multiplicand, the high-half accumulator and the iteration counter. It produces the 2N-bit product with a start/busy/done handshake.

---
 rtl/seq_mult_pkg.sv | 22 ++
 rtl/mult_fsm.sv | 85 ++++++++
 rtl/seq_mult_ctrl.sv | 90 +++++++++
 tb/tb_seq_mult_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_mult_pkg.sv
// seq_mult_pkg
// Shared definitions for the shift-add sequential multiplier slice:
//   state_t    - 2-bit FSM state encoding (IDLE, LOAD, CALC, DONE)
//   DEFAULT_N  - default operand width
//   cnt_width  - width of the iteration counter for a given operand width
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DEFAULT_N = 4;

  // One extra bit so the counter can reach N without wrapping.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/mult_fsm.sv
// mult_fsm
// Sequencing FSM for seq_mult_ctrl. Holds the state register and the
// iteration counter and provides registered state decodes.
// Ports:
//   clk, clr  - clock (rising edge) and async active-high reset
//   start     - operation request, only honoured in IDLE
//   accept    - combinational: start seen in IDLE this cycle
//   busy      - high in LOAD, CALC and DONE
//   done      - one-cycle pulse during DONE
//   load_en   - high during LOAD
//   calc_en   - high during each CALC cycle
module mult_fsm
  import seq_mult_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic clk,
  input  logic clr,
  input  logic start,
  output logic accept,
  output logic busy,
  output logic done,
  output logic load_en,
  output logic calc_en
);

  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t        state;
  logic [CW-1:0] cnt;

  assign accept = (state == IDLE) && start;

  // State register, counter and decodes together. The decodes are
  // registered by setting them from the transition being taken, so each
  // one is valid for exactly the cycle its state is occupied.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state   <= IDLE;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      load_en <= 1'b0;
      calc_en <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= LOAD;
            busy    <= 1'b1;
            load_en <= 1'b1;
          end
        end
        LOAD: begin
          state   <= CALC;
          cnt     <= '0;
          load_en <= 1'b0;
          calc_en <= 1'b1;
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state   <= DONE;
            calc_en <= 1'b0;
            done    <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
          load_en <= 1'b0;
          calc_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/seq_mult_ctrl.sv
// seq_mult_ctrl
// Control and accumulator stage of the shift-add sequential multiplier.
// Drives an external multiplier/low-product shift register and keeps the
// multiplicand, the high-half accumulator and the sequencing FSM.
// Ports:
//   clk, clr            - clock (rising edge) and async active-high reset
//   start, a, b         - request and operands, captured when accepted
//   mq_load, mq_d       - parallel load of the multiplier into the register
//   mq_shiftr, mq_si    - shift-right strobe and serial-in bit
//   mq_so, mq_q         - register bit 0 and full contents (low product)
//   busy, done          - handshake: busy outside IDLE, done pulses once
//   p                   - product {acc, mq_q}
module seq_mult_ctrl
  import seq_mult_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           mq_load,
  output logic           mq_shiftr,
  output logic           mq_si,
  output logic [N-1:0]   mq_d,
  input  logic           mq_so,
  input  logic [N-1:0]   mq_q,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] p
);

  logic [N-1:0] mcand;
  logic [N-1:0] breg;
  logic [N-1:0] acc;
  logic [N:0]   sum;
  logic         accept;
  logic         load_en;
  logic         calc_en;

  mult_fsm #(.N(N)) u_fsm (
    .clk     (clk),
    .clr     (clr),
    .start   (start),
    .accept  (accept),
    .busy    (busy),
    .done    (done),
    .load_en (load_en),
    .calc_en (calc_en)
  );

  // Partial-product add; the carry lands in sum[N] and becomes the top
  // bit of the accumulator after the right shift.
  assign sum = {1'b0, acc} + (mq_so ? {1'b0, mcand} : '0);

  // Operands are latched only on acceptance so a and b are free to move
  // during the operation.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      mcand <= '0;
      breg  <= '0;
    end else if (accept) begin
      mcand <= a;
      breg  <= b;
    end
  end

  // The accumulator is the high product half: cleared on LOAD, shifted
  // right with the new sum each CALC cycle, held otherwise so p stays
  // valid after DONE.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      acc <= '0;
    end else if (load_en) begin
      acc <= '0;
    end else if (calc_en) begin
      acc <= sum[N:1];
    end
  end

  // The bit shifted out of the accumulator feeds the top of the
  // low-product register.
  assign mq_load   = load_en;
  assign mq_d      = load_en ? breg : '0;
  assign mq_shiftr = calc_en;
  assign mq_si     = calc_en & sum[0];
  assign p         = {acc, mq_q};

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// tb_seq_mult_ctrl
// Self-checking bench for seq_mult_ctrl. Models the external multiplier
// shift register for an N=4 and an N=8 instance, keeps a scoreboard of
// expected products and checks the handshake timing.
module tb_seq_mult_ctrl;

  localparam int N  = 4;
  localparam int N8 = 8;

  logic clk = 1'b0;
  logic clr;

  logic           start;
  logic [N-1:0]   a, b;
  logic           mq_load, mq_shiftr, mq_si, mq_so;
  logic [N-1:0]   mq_d, mq_q;
  logic           busy, done;
  logic [2*N-1:0] p;

  logic            start8;
  logic [N8-1:0]   a8, b8;
  logic            mq_load8, mq_shiftr8, mq_si8, mq_so8;
  logic [N8-1:0]   mq_d8, mq_q8;
  logic            busy8, done8;
  logic [2*N8-1:0] p8;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  seq_mult_ctrl #(.N(N)) dut (
    .clk(clk), .clr(clr), .start(start), .a(a), .b(b),
    .mq_load(mq_load), .mq_shiftr(mq_shiftr), .mq_si(mq_si), .mq_d(mq_d),
    .mq_so(mq_so), .mq_q(mq_q), .busy(busy), .done(done), .p(p)
  );

  seq_mult_ctrl #(.N(N8)) dut8 (
    .clk(clk), .clr(clr), .start(start8), .a(a8), .b(b8),
    .mq_load(mq_load8), .mq_shiftr(mq_shiftr8), .mq_si(mq_si8), .mq_d(mq_d8),
    .mq_so(mq_so8), .mq_q(mq_q8), .busy(busy8), .done(done8), .p(p8)
  );

  // Behavioural multiplier/low-product shift registers sharing clr.
  always_ff @(posedge clk or posedge clr) begin
    if (clr)            mq_q <= '0;
    else if (mq_load)   mq_q <= mq_d;
    else if (mq_shiftr) mq_q <= {mq_si, mq_q[N-1:1]};
  end
  assign mq_so = mq_q[0];

  always_ff @(posedge clk or posedge clr) begin
    if (clr)             mq_q8 <= '0;
    else if (mq_load8)   mq_q8 <= mq_d8;
    else if (mq_shiftr8) mq_q8 <= {mq_si8, mq_q8[N8-1:1]};
  end
  assign mq_so8 = mq_q8[0];

  // One comparison: counted, and reported with tag/observed/expected on a miss.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive one request for a single cycle and push its product; returns at
  // the falling edge of the LOAD cycle.
  task automatic applyStimulus(input logic [N-1:0] av, input logic [N-1:0] bv);
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    exp_q.push_back(32'(av) * 32'(bv));
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait (bounded) for done, counting cycles since accept and strobes seen.
  task automatic waitDone(input int c0, output int cycles, output int shifts,
                          output int loads, output int overlap);
    cycles  = c0;
    shifts  = int'(mq_shiftr);
    loads   = int'(mq_load);
    overlap = int'(mq_load & mq_shiftr);
    while (!done && cycles < 40) begin
      @(negedge clk);
      cycles++;
      shifts  += int'(mq_shiftr);
      loads   += int'(mq_load);
      overlap += int'(mq_load & mq_shiftr);
    end
    if (!done) checkOutput("done_timeout", 32'(done), 32'd1);
  endtask

  // Compare p against the oldest scoreboard entry.
  task automatic popCheck(input string tag);
    logic [31:0] e;
    checkOutput({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checkOutput(tag, 32'(p), e);
    end
  endtask

  initial begin
    int cyc, sh, ld, ov, gap, dcount;
    logic [2*N-1:0] held;

    clr = 1'b1; start = 1'b0; a = '0; b = '0;
    start8 = 1'b0; a8 = '0; b8 = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_strobes", {29'd0, mq_load, mq_shiftr, mq_si}, 32'd0);
    checkOutput("rst_mq_d", 32'(mq_d), 32'd0);
    checkOutput("rst_p", 32'(p), 32'd0);
    checkOutput("rst_p8", 32'(p8), 32'd0);
    clr = 1'b0;

    // 13 x 11: latency and product.
    applyStimulus(4'd13, 4'd11);
    checkOutput("13x11_busy", 32'(busy), 32'd1);
    waitDone(1, cyc, sh, ld, ov);
    checkOutput("13x11_latency", 32'(cyc), 32'd6);
    popCheck("13x11_p");
    held = p;
    @(negedge clk);
    checkOutput("13x11_busy_fall", {30'd0, busy, done}, 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("13x11_p_hold", 32'(p), 32'(held));

    // 15 x 15 needs the adder carry.
    applyStimulus(4'd15, 4'd15);
    waitDone(1, cyc, sh, ld, ov);
    popCheck("15x15_p");

    // Zero operands and strobe counts.
    applyStimulus(4'd0, 4'd9);
    waitDone(1, cyc, sh, ld, ov);
    popCheck("0x9_p");
    checkOutput("0x9_shifts", 32'(sh), 32'd4);
    checkOutput("0x9_loads", 32'(ld), 32'd1);
    checkOutput("0x9_overlap", 32'(ov), 32'd0);
    applyStimulus(4'd9, 4'd0);
    waitDone(1, cyc, sh, ld, ov);
    popCheck("9x0_p");
    checkOutput("9x0_shifts", 32'(sh), 32'd4);
    checkOutput("9x0_loads", 32'(ld), 32'd1);

    // Start during CALC with other operands is ignored and not queued.
    applyStimulus(4'd6, 4'd7);
    @(negedge clk);
    a = 4'd2; b = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone(3, cyc, sh, ld, ov);
    checkOutput("ignore_latency", 32'(cyc), 32'd6);
    popCheck("ignore_p");
    dcount = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      dcount += int'(busy) + int'(done);
    end
    checkOutput("ignore_no_queue", 32'(dcount), 32'd0);

    // Start held high: back-to-back products 7 cycles apart.
    @(negedge clk);
    a = 4'd5; b = 4'd6; start = 1'b1;
    exp_q.push_back(32'd30);
    @(negedge clk);
    a = 4'd7; b = 4'd9;
    exp_q.push_back(32'd63);
    waitDone(1, cyc, sh, ld, ov);
    checkOutput("held1_latency", 32'(cyc), 32'd6);
    popCheck("held1_p");
    @(negedge clk);
    checkOutput("held_idle_gap", 32'(busy), 32'd0);
    @(negedge clk);
    start = 1'b0;
    waitDone(1, cyc, sh, ld, ov);
    gap = 2 + cyc - 1;
    checkOutput("held_period", 32'(gap), 32'd7);
    popCheck("held2_p");

    // Async clear mid-CALC aborts without done.
    applyStimulus(4'd13, 4'd11);
    repeat (2) @(negedge clk);
    clr = 1'b1;
    #1;
    checkOutput("abort_outputs", {27'd0, busy, done, mq_load, mq_shiftr, mq_si}, 32'd0);
    checkOutput("abort_p", 32'(p), 32'd0);
    void'(exp_q.pop_back());
    @(negedge clk);
    clr = 1'b0;
    dcount = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      dcount += int'(busy) + int'(done);
    end
    checkOutput("abort_no_done", 32'(dcount), 32'd0);
    applyStimulus(4'd3, 4'd5);
    waitDone(1, cyc, sh, ld, ov);
    popCheck("after_abort_3x5");

    // N=8 instance: 255 x 255.
    @(negedge clk);
    a8 = 8'd255; b8 = 8'd255; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    cyc = 1;
    while (!done8 && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("n8_latency", 32'(cyc), 32'd10);
    checkOutput("n8_p", 32'(p8), 32'h0000FE01);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
